// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage in front of the instruction decoder.
// Owns the fetch PC, issues word reads over a req/ack handshake, buffers the
// returned {imm, instr} words in a small circular prefetch queue and presents
// the head entry to the decoder. Jumps flush the queue and redirect the PC;
// a request already in flight is never withdrawn, and its data is dropped.
//
// Build option: define INSTR_FETCH_PREFETCH_EN to run the queue at QDEPTH
// entries with requests issued ahead of consumption. Without it the queue
// holds a single entry and a new request waits until the head is consumed.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | no request outstanding; waits for queue space or a jump
// S_REQ     | request to fetch_addr outstanding; data is kept on ack
// S_DISCARD | request outstanding from before a jump; data is dropped

module instr_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        fetch_req,
    output logic [15:0] fetch_addr,
    input  logic        fetch_ack,
    input  logic [31:0] fetch_data,
    output logic [15:0] instr,
    output logic [15:0] imm,
    output logic [15:0] instr_pc,
    output logic        instr_valid,
    input  logic        advance,
    input  logic        jump,
    input  logic [15:0] jump_target
);

`ifdef INSTR_FETCH_PREFETCH_EN
    localparam int DEPTH = (QDEPTH >= 2) ? 2 : 1;
`else
    // without prefetch the queue never grows past one entry
    localparam int DEPTH = (QDEPTH > 1) ? 1 : QDEPTH;
`endif

    localparam logic [1:0] DEPTH_C  = 2'(DEPTH);
    localparam logic       PTR_LAST = 1'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DISCARD
    } state_t;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] imm;
        logic [15:0] pc;
    } entry_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic [15:0] addr_q, addr_d;
    entry_t      q_mem_q [DEPTH];
    entry_t      q_mem_d [DEPTH];
    logic        head_q, head_d;
    logic        tail_q, tail_d;
    logic [1:0]  count_q, count_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] imm_q, imm_d;
    logic [15:0] ipc_q, ipc_d;
    logic        valid_q, valid_d;

    logic        push;
    logic        pop;
    logic        space;
    logic [15:0] redirect_pc;
    entry_t      head_e;

    function automatic logic ptr_inc(input logic p);
        return (p == PTR_LAST) ? 1'b0 : ~p;
    endfunction

    // queue bookkeeping, fetch FSM next state and next head outputs
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = req_q;
        addr_d  = addr_q;
        q_mem_d = q_mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        // only an ack to a live request in S_REQ carries usable data
        push        = (state_q == S_REQ) && fetch_ack && !jump;
        pop         = advance && valid_q && !jump;
        redirect_pc = jump ? jump_target : pc_q;

        if (jump) begin
            head_d  = 1'b0;
            tail_d  = 1'b0;
            count_d = 2'd0;
        end else begin
            if (push) begin
                q_mem_d[tail_q].instr = fetch_data[15:0];
                q_mem_d[tail_q].imm   = fetch_data[31:16];
                q_mem_d[tail_q].pc    = addr_q;
                tail_d                = ptr_inc(tail_q);
            end
            if (pop) begin
                head_d = ptr_inc(head_q);
            end
            if (push && !pop) begin
                count_d = count_q + 2'd1;
            end else if (pop && !push) begin
                count_d = count_q - 2'd1;
            end
        end

        // space is judged after this cycle's push/pop; no request is in flight
        // once we leave S_REQ on an ack, so count alone decides
        space = (count_d < DEPTH_C);

        case (state_q)
            S_IDLE: begin
                if (jump || space) begin
                    state_d = S_REQ;
                    req_d   = 1'b1;
                    addr_d  = redirect_pc;
                    pc_d    = redirect_pc;
                end
            end
            S_REQ: begin
                if (fetch_ack) begin
                    if (jump) begin
                        // acked word is dropped; go straight to the target
                        pc_d   = jump_target;
                        addr_d = jump_target;
                    end else begin
                        pc_d   = pc_q + 16'd1;
                        addr_d = pc_q + 16'd1;
                        if (!space) begin
                            state_d = S_IDLE;
                            req_d   = 1'b0;
                        end
                    end
                end else if (jump) begin
                    state_d = S_DISCARD;
                    pc_d    = jump_target;
                end
            end
            S_DISCARD: begin
                pc_d = redirect_pc;
                if (fetch_ack) begin
                    state_d = S_REQ;
                    addr_d  = redirect_pc;
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase

        head_e  = q_mem_d[head_d];
        valid_d = (count_d != 2'd0);
        instr_d = valid_d ? head_e.instr : 16'h0000;
        imm_d   = valid_d ? head_e.imm   : 16'h0000;
        ipc_d   = valid_d ? head_e.pc    : 16'h0000;
    end

    // all state and outputs registered; queue storage needs no reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
            instr_q <= 16'h0000;
            imm_q   <= 16'h0000;
            ipc_q   <= 16'h0000;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            instr_q <= instr_d;
            imm_q   <= imm_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
        end
        q_mem_q <= q_mem_d;
    end

    assign fetch_req   = req_q;
    assign fetch_addr  = addr_q;
    assign instr       = instr_q;
    assign imm         = imm_q;
    assign instr_pc    = ipc_q;
    assign instr_valid = valid_q;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage directly upstream of the instruction decoder. It owns the fetch program counter and issues word reads to instruction memory through a req/ack handshake. It buffers returned 32-bit instruction words (16-bit opcode word plus 16-bit immediate) in a small prefetch queue and presents the head entry to the decoder. It consumes the decoder's advance and jump controls, and flushes and redirects on taken jumps, `jal` and `irt`.

## Interface
Parameters:
- `RESET_PC`, 16'h0000: fetch address after reset.
- `QDEPTH`, 2: prefetch queue entries; legal values are 1 and 2.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `fetch_req` out 1: memory read request.
- `fetch_addr` out 16: instruction word address.
- `fetch_ack` in 1: one-cycle pulse; `fetch_data` is valid in the same cycle.
- `fetch_data` in 32: [15:0] instruction word, [31:16] immediate.
- `instr` out 16: head instruction to the decoder; reads 16'h0000 (decodes as nop) when the queue is empty.
- `imm` out 16: head immediate; 16'h0000 when the queue is empty.
- `instr_pc` out 16: address of the head entry.
- `instr_valid` out 1: the queue head holds a valid entry.
- `advance` in 1: pop the head; the core drives it as decoder pc_inc gated by stall.
- `jump` in 1: redirect the fetch stream; driven from decoder pc_ie.
- `jump_target` in 16: new fetch address, sampled when `jump`=1.

## Operation
- Queue: circular buffer of {instr, imm, pc} entries, with a head pointer, tail pointer and count. Each entry is written on an accepted `fetch_ack` and popped on `advance` when `instr_valid`=1.
- Fetch state machine:
  - IDLE: `fetch_req`=0. Move to REQ when count + outstanding < `QDEPTH`.
  - REQ: `fetch_req`=1 and `fetch_addr`=pc, held stable until `fetch_ack`. On ack, set pc = pc+1 (16-bit wrap, FFFF→0000). Then stay in REQ if space remains, else go to IDLE.
  - DISCARD: entered when `jump` is seen while a request is outstanding. Hold `fetch_req` and `fetch_addr` unchanged; a request is never withdrawn. Drop the returning data, then go to REQ at the redirected pc.
- Jump: clear the queue (count=0), set pc = `jump_target`, and drop `instr_valid` next cycle.
  - `jump` and `advance` in the same cycle: `jump` wins and the queue is flushed.
  - `jump` and `fetch_ack` in the same cycle: the acked data is discarded and no DISCARD state is needed.
- `advance` while empty: ignored, with no pointer movement.
- `advance` and `fetch_ack` in the same cycle with the queue full: cannot occur, because requests are only issued when there is free space counting the outstanding request.
- `fetch_ack` with no outstanding request (for example after reset): ignored.
- Reset values: `fetch_req`=0, `fetch_addr`=`RESET_PC`, pc=`RESET_PC`, `instr`=0, `imm`=0, `instr_pc`=0, `instr_valid`=0, queue empty, state IDLE. Reset mid-transaction abandons the request; memory is reset on the same `rst`.

## Timing
- First `fetch_req` is asserted in the first cycle after `rst` deasserts.
- Ack in cycle N: the entry is visible on `instr` and `instr_valid` at N+1. With an empty queue, fetch-to-decode latency is one cycle beyond memory latency.
- After an ack, `fetch_req` for the next address is asserted at N+1 if space remains. Back-to-back single-cycle acks therefore sustain one instruction per cycle.
- `jump` in cycle J:
  - `fetch_req` with `fetch_addr`=`jump_target` at J+1 if no request was outstanding.
  - Otherwise at A+1, where A is the cycle in which the stale ack arrives.
  - `instr_valid`=0 from J+1 until the first post-jump ack is registered.
- All outputs are registered; there is no combinational path from `advance` or `jump` to `fetch_req`.

## Configuration
- `INSTR_FETCH_PREFETCH_EN` defined: the queue uses `QDEPTH` entries and requests are issued ahead of consumption.
- Not defined: effective depth is 1. A new request is issued only after the head is popped or flushed, giving at most one instruction per two cycles. The `QDEPTH` parameter is ignored.

## Test plan
- Reset with `RESET_PC`=16'h0100 and memory returning acks 1 cycle after each req → `fetch_addr` sequence is 0100, 0101, 0102. The first `instr_valid` appears two cycles after the first req.
- `advance` held at 0 with prefetch on → exactly 2 acks are accepted and `fetch_req` drops. `advance` for one cycle → exactly one new req is issued at 0102.
- `jump`=1 with `jump_target`=16'h0040 while a req to 0103 is pending with a 3-cycle ack → the 0103 data is never presented on `instr`. The next req is to 0040, and the next valid `instr_pc`=0040.
- `jump` and `fetch_ack` in the same cycle → the acked word is dropped, and `fetch_req` to the target is asserted the next cycle.
- pc=16'hFFFF fetched and acked → the next `fetch_addr` is 16'h0000 and `instr_pc` of the head is FFFF.
- `advance`=1 on an empty queue, then `rst` asserted while `fetch_req`=1 → no pointer change. After reset `fetch_req`=0, `instr`=0, `instr_valid`=0, and a stray ack is ignored.
